// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the Phase 1 control-step sequencer: opcode
// constants, the control-step state encoding, IR field positions and the
// opcode classification used to pick the execute sequence.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

   // Opcodes handled by the sequencer
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHRA = 5'd10;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;

   // IR field bit positions
   localparam int IR_OP_MSB = 31;
   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_MSB = 26;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_MSB = 22;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_MSB = 18;
   localparam int IR_RC_LSB = 15;

   // Control steps
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_T5   = 3'd6,
      ST_T6   = 3'd7
   } state_e;

   // Execute-sequence families
   typedef enum logic [1:0] {
      CLS_ALU3    = 2'd0,
      CLS_MULDIV  = 2'd1,
      CLS_UNARY   = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_e;

   function automatic op_class_e op_class(input logic [4:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_ALU3;
         OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                  cls = CLS_UNARY;
         default:                         cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/reg_decode_4to16.sv
// ---------------------------------------------------------------------------
// reg_decode_4to16
// Turns a 4-bit register field into a 16-bit one-hot select.
// Ports:
//   en_i      enable; output is all zero when low
//   sel_i     register number 0..15
//   onehot_o  one-hot select, bit n set for register n
// ---------------------------------------------------------------------------
module reg_decode_4to16 (
   input  logic        en_i,
   input  logic [3:0]  sel_i,
   output logic [15:0] onehot_o
);

   // One-hot decode of the register number, gated by the enable
   always_comb begin
      onehot_o = 16'h0000;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end else begin
         onehot_o = 16'h0000;
      end
   end

endmodule

// File: rtl/alu_step_sequencer.sv
// ---------------------------------------------------------------------------
// alu_step_sequencer
// Fetch/execute control-step sequencer for register-register ALU,
// multiply/divide and unary instructions around the shared 32-bit bus.
// Ports:
//   clock, clear        rising-edge clock, synchronous active-high reset
//   start               begin one instruction (only looked at in IDLE)
//   ir_in               IR contents: opcode, ra, rb, rc fields
//   mem_done            memory read complete (only looked at in T1)
//   gpr_out / gpr_in    one-hot register drive selects / load enables
//   PCout..Zhighout     remaining bus drive selects
//   PCin..LOin          remaining load enables
//   IncPC, Read, alu_op ALU and MDR-mux controls
//   busy, done, illegal, mem_timeout  status
// ---------------------------------------------------------------------------
module alu_step_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir_in,
   input  logic        mem_done,
   output logic [15:0] gpr_out,
   output logic [15:0] gpr_in,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zin,
   output logic        HIin,
   output logic        LOin,
   output logic        IncPC,
   output logic        Read,
   output logic [4:0]  alu_op,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        mem_timeout
);

   localparam logic [3:0] WAIT_MAX_C = 4'(MEM_WAIT_MAX);

   state_e      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;

   logic [4:0]  opcode_s;
   logic [3:0]  ra_s, rb_s, rc_s;
   op_class_e   cls_s;
   logic        out_en_s, in_en_s;
   logic [3:0]  out_sel_s;
   logic        ir_unused_s;

   assign opcode_s    = ir_in[IR_OP_MSB:IR_OP_LSB];
   assign ra_s        = ir_in[IR_RA_MSB:IR_RA_LSB];
   assign rb_s        = ir_in[IR_RB_MSB:IR_RB_LSB];
   assign rc_s        = ir_in[IR_RC_MSB:IR_RC_LSB];
   assign cls_s       = op_class(opcode_s);
   assign ir_unused_s = ^ir_in[14:0];

   reg_decode_4to16 u_out_dec (
      .en_i     (out_en_s),
      .sel_i    (out_sel_s),
      .onehot_o (gpr_out)
   );

   // Load enables only ever target the destination field ra
   reg_decode_4to16 u_in_dec (
      .en_i     (in_en_s),
      .sel_i    (ra_s),
      .onehot_o (gpr_in)
   );

   // State and T1 wait-counter registers with synchronous clear
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state selection and per-step control decode
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      out_en_s    = 1'b0;
      out_sel_s   = 4'd0;
      in_en_s     = 1'b0;
      PCout       = 1'b0;
      MDRout      = 1'b0;
      Zlowout     = 1'b0;
      Zhighout    = 1'b0;
      PCin        = 1'b0;
      IRin        = 1'b0;
      MARin       = 1'b0;
      MDRin       = 1'b0;
      Yin         = 1'b0;
      Zin         = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      IncPC       = 1'b0;
      Read        = 1'b0;
      alu_op      = 5'd0;
      done        = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      busy        = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_T0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_T0: begin
            PCout      = 1'b1;
            MARin      = 1'b1;
            IncPC      = 1'b1;
            Zin        = 1'b1;
            wait_cnt_d = 4'd0;
            state_d    = ST_T1;
         end
         ST_T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            // PC+1 is written back only once, on the first wait cycle
            if (wait_cnt_q == 4'd0) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end else begin
               Zlowout = 1'b0;
               PCin    = 1'b0;
            end
            if (mem_done) begin
               state_d = ST_T2;
            end else if (wait_cnt_q >= WAIT_MAX_C) begin
               mem_timeout = 1'b1;
               state_d     = ST_IDLE;
            end else if (wait_cnt_q != 4'hF) begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
         end
         ST_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = ST_T3;
         end
         ST_T3: begin
            case (cls_s)
               CLS_ALU3: begin
                  out_en_s  = 1'b1;
                  out_sel_s = rb_s;
                  Yin       = 1'b1;
                  state_d   = ST_T4;
               end
               CLS_MULDIV: begin
                  out_en_s  = 1'b1;
                  out_sel_s = ra_s;
                  Yin       = 1'b1;
                  state_d   = ST_T4;
               end
               CLS_UNARY: begin
                  out_en_s  = 1'b1;
                  out_sel_s = rb_s;
                  alu_op    = opcode_s;
                  Zin       = 1'b1;
                  state_d   = ST_T4;
               end
               default: begin
                  illegal = 1'b1;
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end
            endcase
         end
         ST_T4: begin
            case (cls_s)
               CLS_ALU3, CLS_MULDIV: begin
                  out_en_s  = 1'b1;
                  out_sel_s = (cls_s == CLS_ALU3) ? rc_s : rb_s;
                  alu_op    = opcode_s;
                  Zin       = 1'b1;
                  state_d   = ST_T5;
               end
               CLS_UNARY: begin
                  Zlowout = 1'b1;
                  in_en_s = 1'b1;
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
         ST_T5: begin
            Zlowout = 1'b1;
            if (cls_s == CLS_MULDIV) begin
               LOin    = 1'b1;
               state_d = ST_T6;
            end else begin
               in_en_s = 1'b1;
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_step_sequencer
// Self-checking bench: a step-table model expands each instruction into the
// expected per-cycle output vectors; a negedge process compares the DUT
// against the current expected vector and checks the bus-drive invariant.
// ---------------------------------------------------------------------------
module tb_alu_step_sequencer;

   logic        clock = 1'b0;
   logic        clear, start, mem_done;
   logic [31:0] ir_in;
   logic [15:0] gpr_out, gpr_in;
   logic        PCout, MDRout, Zlowout, Zhighout;
   logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
   logic        IncPC, Read, busy, done, illegal, mem_timeout;
   logic [4:0]  alu_op;

   typedef struct packed {
      logic [15:0] gout;
      logic [15:0] gin;
      logic pcout, mdrout, zlo, zhi;
      logic pcin, irin, marin, mdrin, yin, zin, hiin, loin;
      logic incpc, read;
      logic [4:0] aluop;
      logic busy, done, illegal, tmo;
   } ov_t;

   ov_t exp_q[$];
   ov_t exp_v;
   ov_t act_v;
   bit  chk_en = 1'b0;
   int  n_chk  = 0;
   int  n_pass = 0;
   int  cyc    = 0;

   alu_step_sequencer #(.MEM_WAIT_MAX(15)) dut (
      .clock(clock), .clear(clear), .start(start), .ir_in(ir_in), .mem_done(mem_done),
      .gpr_out(gpr_out), .gpr_in(gpr_in),
      .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
      .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .alu_op(alu_op),
      .busy(busy), .done(done), .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, act, req);
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   // Expand one instruction into expected output vectors, one per cycle after start.
   // w = number of T1 cycles before mem_done; w > 15 means mem_done never comes.
   function automatic void gen_seq(input logic [31:0] ir, input int w);
      ov_t v;
      int  op, ra, rb, rc, kmax;
      op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
      exp_q.delete();
      v = '0; v.busy = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1;
      exp_q.push_back(v);
      kmax = (w > 15) ? 15 : w;
      for (int k = 0; k <= kmax; k++) begin
         v = '0; v.busy = 1; v.read = 1; v.mdrin = 1;
         if (k == 0) begin v.zlo = 1; v.pcin = 1; end
         if (w > 15 && k == 15) v.tmo = 1;
         exp_q.push_back(v);
      end
      if (w > 15) return;
      v = '0; v.busy = 1; v.mdrout = 1; v.irin = 1; exp_q.push_back(v);
      if (op >= 3 && op <= 11) begin
         v = '0; v.busy = 1; v.gout = 16'h1 << rb; v.yin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.gout = 16'h1 << rc; v.aluop = 5'(op); v.zin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zlo = 1; v.gin = 16'h1 << ra; v.done = 1; exp_q.push_back(v);
      end else if (op == 15 || op == 16) begin
         v = '0; v.busy = 1; v.gout = 16'h1 << ra; v.yin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.gout = 16'h1 << rb; v.aluop = 5'(op); v.zin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zlo = 1; v.loin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zhi = 1; v.hiin = 1; v.done = 1; exp_q.push_back(v);
      end else if (op == 17 || op == 18) begin
         v = '0; v.busy = 1; v.gout = 16'h1 << rb; v.aluop = 5'(op); v.zin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zlo = 1; v.gin = 16'h1 << ra; v.done = 1; exp_q.push_back(v);
      end else begin
         v = '0; v.busy = 1; v.illegal = 1; v.done = 1; exp_q.push_back(v);
      end
   endfunction

   // Per-cycle comparison against the model and the single-bus-driver rule
   always @(negedge clock) begin
      cyc++;
      if (chk_en) begin
         act_v = {gpr_out, gpr_in, PCout, MDRout, Zlowout, Zhighout, PCin, IRin, MARin,
                  MDRin, Yin, Zin, HIin, LOin, IncPC, Read, alu_op, busy, done, illegal,
                  mem_timeout};
         check("outputs", 64'(act_v), 64'(exp_v));
         check("bus_onehot", 64'($countones({gpr_out, PCout, MDRout, Zlowout, Zhighout}) <= 1), 64'd1);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0; mem_done = 1'($urandom_range(0, 1)); exp_v = '0;
         @(posedge clock); #1;
      end
   endtask

   // Run one instruction from an IDLE cycle; clr_at > 0 asserts clear in that cycle.
   task automatic run_instr(input logic [31:0] ir, input int w, input int clr_at, input bit rnd_start);
      int n, kmax;
      gen_seq(ir, w);
      n = exp_q.size();
      kmax = (w > 15) ? 15 : w;
      ir_in = ir; start = 1'b1; mem_done = 1'($urandom_range(0, 1)); exp_v = '0;
      @(posedge clock); #1;
      for (int c = 1; c <= n; c++) begin
         exp_v = exp_q[c-1];
         start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
         if (c >= 2 && c <= 2 + kmax) mem_done = (c - 2 == w);
         else mem_done = 1'($urandom_range(0, 1));
         if (c == clr_at) clear = 1'b1;
         @(posedge clock); #1;
         if (c == clr_at) begin
            clear = 1'b0;
            break;
         end
      end
      start = 1'b0; exp_v = '0;
   endtask

   initial begin
      int op, w, clr;
      clear = 1'b1; start = 1'b1; mem_done = 1'b0; ir_in = 32'd0; exp_v = '0;
      @(posedge clock); #1;
      chk_en = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0; start = 1'b0;
      idle(2);

      // Model pins against hand-derived step tables
      gen_seq(mk_ir(5'd3, 4'd2, 4'd3, 4'd4), 0);
      check("pin_add_len", 64'(exp_q.size()), 64'd6);
      check("pin_add_t3", 64'(exp_q[3].gout), 64'h0008);
      check("pin_add_t4", 64'({exp_q[4].gout, exp_q[4].aluop}), 64'({16'h0010, 5'd3}));
      check("pin_add_t5", 64'({exp_q[5].gin, exp_q[5].done}), 64'({16'h0004, 1'b1}));
      gen_seq(mk_ir(5'd15, 4'd5, 4'd6, 4'd0), 3);
      check("pin_mul_len", 64'(exp_q.size()), 64'd10);
      check("pin_mul_hi", 64'({exp_q[8].loin, exp_q[9].hiin, exp_q[9].done}), 64'h7);
      gen_seq(mk_ir(5'd18, 4'd1, 4'd7, 4'd0), 0);
      check("pin_not", 64'({exp_q.size(), exp_q[4].gin}), 64'({32'd5, 16'h0002}));
      gen_seq(mk_ir(5'd31, 4'd0, 4'd0, 4'd0), 0);
      check("pin_ill", 64'({exp_q.size(), exp_q[3].illegal}), 64'({32'd4, 1'b1}));
      gen_seq(mk_ir(5'd3, 4'd0, 4'd0, 4'd0), 16);
      check("pin_tmo", 64'({exp_q.size(), exp_q[16].tmo}), 64'({32'd17, 1'b1}));

      // Directed instructions against the DUT
      run_instr(mk_ir(5'd3, 4'd2, 4'd3, 4'd4), 0, 0, 1'b0);
      run_instr(mk_ir(5'd15, 4'd5, 4'd6, 4'd0), 3, 0, 1'b0);
      run_instr(mk_ir(5'd18, 4'd1, 4'd7, 4'd0), 0, 0, 1'b0);
      run_instr(mk_ir(5'd31, 4'd0, 4'd0, 4'd0), 0, 0, 1'b0);
      idle(1);
      run_instr(mk_ir(5'd3, 4'd2, 4'd3, 4'd4), 16, 0, 1'b0);
      idle(1);
      run_instr(mk_ir(5'd3, 4'd2, 4'd3, 4'd4), 0, 5, 1'b0);
      idle(1);

      // Random instruction stream
      for (int i = 0; i < 1000; i++) begin
         op  = $urandom_range(0, 31);
         w   = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
         clr = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 5) : 0;
         run_instr(mk_ir(5'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15))), w, clr, 1'b1);
         idle($urandom_range(0, 1));
      end
      idle(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
